// File: rtl/arbitro_salida_if.sv
// Bundles the class-FIFO heads, the downstream almost-full flag and the
// arbiter's pop/push/data outputs.
// The slave modport is the arbiter's view; master is the surrounding FIFO logic.
interface arbitro_salida_if #(
  parameter int WIDTH = 6
);
  logic [3:0]       empty;
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic [WIDTH-1:0] data_in3;
  logic             almost_full;
  logic [3:0]       pop;
  logic             push;
  logic [WIDTH-1:0] data_out;
  logic [1:0]       class_out;

  modport master (
    output empty, data_in0, data_in1, data_in2, data_in3, almost_full,
    input  pop, push, data_out, class_out
  );

  modport slave (
    input  empty, data_in0, data_in1, data_in2, data_in3, almost_full,
    output pop, push, data_out, class_out
  );
endinterface

// File: rtl/arbitro_salida.sv
// Round-robin output arbiter: drains four show-ahead class FIFOs into one
// downstream FIFO, one word per cycle, with a registered push stage.
// Optional per-class push counters are built only when the macro
// ARBITRO_SALIDA_CNT_EN is defined; otherwise cnt0..cnt3 are tied to zero.
//
// state | meaning
// IDLE  | every class FIFO empty, nothing to pop
// SERVE | at least one class pending and downstream has room
// HOLD  | downstream almost full, pops blocked
module arbitro_salida #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  arbitro_salida_if.slave    bus,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1,
  output logic [CNT_W-1:0]   cnt2,
  output logic [CNT_W-1:0]   cnt3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q;
  logic             push_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       class_q;

  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             found;
  logic             pop_en;
  logic [WIDTH-1:0] din [4];

  assign din[0] = bus.data_in0;
  assign din[1] = bus.data_in1;
  assign din[2] = bus.data_in2;
  assign din[3] = bus.data_in3;

  // Grant search from rr_ptr, pop gating and next-state decode.
  always_comb begin
    grant = rr_ptr_q;
    idx   = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && !bus.empty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    // almost_full blocks the pop in the same cycle; the push already
    // registered from the previous pop still goes out.
    pop_en  = !reset && !bus.almost_full && (bus.empty != 4'b1111);
    bus.pop = pop_en ? (4'b0001 << grant) : 4'b0000;
    if (bus.almost_full)
      state_d = HOLD;
    else if (bus.empty == 4'b1111)
      state_d = IDLE;
    else
      state_d = SERVE;
  end

  // FSM state, round-robin pointer and the registered push stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      push_q   <= 1'b0;
      data_q   <= '0;
      class_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      push_q  <= pop_en;
      if (pop_en) begin
        data_q   <= din[grant];
        class_q  <= grant;
        rr_ptr_q <= grant + 2'd1;
      end
    end
  end

  assign bus.push      = push_q;
  assign bus.data_out  = data_q;
  assign bus.class_out = class_q;
  assign state         = state_q;

`ifdef ARBITRO_SALIDA_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  // Count each push against its class; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= '0;
    end else if (push_q) begin
      cnt_q[class_q] <= cnt_q[class_q] + CNT_W'(1);
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
  assign cnt2 = '0;
  assign cnt3 = '0;
`endif

endmodule

// File: tb/tb_arbitro_salida.sv
// Bench for arbitro_salida: directed phases followed by random traffic,
// checked against a round-robin reference model and a push scoreboard.
module tb_arbitro_salida;
  localparam int W  = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    state;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

  arbitro_salida_if #(.WIDTH(W)) bus ();

  arbitro_salida #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state),
    .cnt0  (cnt0),
    .cnt1  (cnt1),
    .cnt2  (cnt2),
    .cnt3  (cnt3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   c;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    ptr   = 0;
  int    exp_state = 0;
  int    last_d = 0;
  int    last_c = 0;
  int    mcnt [4] = '{0, 0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, predict pop from the model, queue the
  // expected push and record the expected next state.
  task automatic cyc(input logic r, input logic [3:0] e, input logic af,
                     input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic [W-1:0] d2, input logic [W-1:0] d3);
    int           g;
    int           c;
    logic [3:0]   exp_pop;
    logic [W-1:0] dv [4];
    item_t        it;
    @(negedge clk);
    reset = r;
    bus.empty = e;
    bus.almost_full = af;
    bus.data_in0 = d0;
    bus.data_in1 = d1;
    bus.data_in2 = d2;
    bus.data_in3 = d3;
    #1;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    g = -1;
    if (!r && !af && e != 4'b1111) begin
      for (int k = 0; k < 4; k++) begin
        c = (ptr + k) % 4;
        if (g < 0 && !e[c]) g = c;
      end
    end
    exp_pop = (g < 0) ? 4'b0000 : (4'b0001 << g);
    chk("pop", {28'd0, bus.pop}, {28'd0, exp_pop});
    if (g >= 0) begin
      it.d = dv[g];
      it.c = g[1:0];
      sb.push_back(it);
      ptr = (g + 1) % 4;
    end
    if (r) ptr = 0;
    exp_state = r ? 0 : af ? 2 : (e == 4'b1111) ? 0 : 1;
  endtask

  task automatic rnd_cyc(input logic r, input logic [3:0] e, input logic af);
    cyc(r, e, af, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  // Monitor: after each edge, match push against the scoreboard and check
  // held outputs, state and counters.
  initial begin
    item_t it;
    int    exp_cnt [4];
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        last_d = 0;
        last_c = 0;
      end
      chk("push", {31'd0, bus.push}, (sb.size() != 0 && !reset) ? 32'd1 : 32'd0);
      if (reset) sb.delete();
      if (bus.push && sb.size() != 0) begin
        it = sb.pop_front();
        last_d = int'(it.d);
        last_c = int'(it.c);
      end else if (sb.size() != 0) begin
        sb.delete();
      end
      chk("data_out", {{(32-W){1'b0}}, bus.data_out}, last_d);
      chk("class_out", {30'd0, bus.class_out}, last_c);
      chk("state", {30'd0, state}, exp_state);
`ifdef ARBITRO_SALIDA_CNT_EN
      for (int i = 0; i < 4; i++) exp_cnt[i] = mcnt[i];
`else
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
`endif
      chk("cnt0", {24'd0, cnt0}, exp_cnt[0]);
      chk("cnt1", {24'd0, cnt1}, exp_cnt[1]);
      chk("cnt2", {24'd0, cnt2}, exp_cnt[2]);
      chk("cnt3", {24'd0, cnt3}, exp_cnt[3]);
      if (bus.push === 1'b1 && !reset)
        mcnt[bus.class_out] = (mcnt[bus.class_out] + 1) % 256;
    end
  end

  initial begin
    bus.empty = 4'b1111;
    bus.almost_full = 1'b0;
    bus.data_in0 = '0;
    bus.data_in1 = '0;
    bus.data_in2 = '0;
    bus.data_in3 = '0;

    // Reset and idle with all FIFOs empty.
    repeat (5) cyc(1'b1, 4'b1111, 1'b0, 0, 0, 0, 0);
    repeat (5) cyc(1'b0, 4'b1111, 1'b0, 0, 0, 0, 0);

    // All classes ready: strict rotation 0,1,2,3,0...
    repeat (8) cyc(1'b0, 4'b0000, 1'b0, 6'd10, 6'd11, 6'd12, 6'd13);

    // Move rr_ptr to 1, then only classes 0 and 2 ready.
    cyc(1'b1, 4'b1111, 1'b0, 0, 0, 0, 0);
    cyc(1'b0, 4'b1110, 1'b0, 6'd5, 0, 0, 0);
    repeat (4) cyc(1'b0, 4'b1010, 1'b0, 6'd20, 6'd21, 6'd22, 6'd23);

    // Streaming with a three-cycle almost_full window.
    repeat (3) rnd_cyc(1'b0, 4'b0000, 1'b0);
    repeat (3) rnd_cyc(1'b0, 4'b0000, 1'b1);
    repeat (4) rnd_cyc(1'b0, 4'b0000, 1'b0);

    // Reset lands on the cycle that would pop class 2.
    cyc(1'b1, 4'b1111, 1'b0, 0, 0, 0, 0);
    rnd_cyc(1'b0, 4'b0000, 1'b0);
    rnd_cyc(1'b0, 4'b0000, 1'b0);
    rnd_cyc(1'b1, 4'b0000, 1'b0);
    rnd_cyc(1'b0, 4'b0000, 1'b0);

    // 257 pushes of class 3 wrap its counter to 1.
    cyc(1'b1, 4'b1111, 1'b0, 0, 0, 0, 0);
    repeat (257) rnd_cyc(1'b0, 4'b0111, 1'b0);
    repeat (2) cyc(1'b0, 4'b1111, 1'b0, 0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++)
      rnd_cyc(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));

    repeat (3) cyc(1'b0, 4'b1111, 1'b0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
